// File: rtl/pcounter_stack.sv
// rtl/pcounter_stack.sv - program counter with hardware call/return stack
// Optional build macro: PC_STACK_PROTECT_EN (reject CALL while full instead of
// overwriting the oldest return address).
module pcounter_stack #(
  parameter int              PC_W      = 13,
  parameter int              DEPTH     = 8,
  parameter logic [PC_W-1:0] RESET_VEC = '0
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     en,
  input  logic [2:0]               op,
  input  logic [PC_W-1:0]          target,
  output logic [PC_W-1:0]          counter,
  output logic [$clog2(DEPTH):0]   sp,
  output logic [PC_W-1:0]          tos,
  output logic                     full,
  output logic                     empty,
  output logic                     overflow,
  output logic                     underflow
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam int SP_W  = IDX_W + 1;
  localparam logic [SP_W-1:0] SP_FULL = SP_W'(DEPTH);

  localparam logic [2:0] OP_INC  = 3'b000;
  localparam logic [2:0] OP_SKIP = 3'b001;
  localparam logic [2:0] OP_JUMP = 3'b010;
  localparam logic [2:0] OP_CALL = 3'b011;
  localparam logic [2:0] OP_RET  = 3'b100;

  logic [PC_W-1:0]  stack_mem [DEPTH];
  logic [IDX_W-1:0] wr;
  logic [IDX_W-1:0] wr_prev;
  logic [PC_W-1:0]  pc_inc;
  logic [PC_W-1:0]  pc_skip;

  logic [PC_W-1:0]  counter_n;
  logic [SP_W-1:0]  sp_n;
  logic [IDX_W-1:0] wr_n;
  logic             overflow_n;
  logic             underflow_n;
  logic             push;

  // Wrapping address arithmetic; wr_prev indexes the newest entry.
  assign pc_inc  = counter + PC_W'(1);
  assign pc_skip = counter + PC_W'(2);
  assign wr_prev = wr - IDX_W'(1);

  assign full  = (sp == SP_FULL);
  assign empty = (sp == '0);
  assign tos   = empty ? '0 : stack_mem[wr_prev];

  // Next-state decode of the requested operation.
  always_comb begin
    counter_n   = counter;
    sp_n        = sp;
    wr_n        = wr;
    overflow_n  = overflow;
    underflow_n = underflow;
    push        = 1'b0;
    if (en) begin
      case (op)
        OP_INC:  counter_n = pc_inc;
        OP_SKIP: counter_n = pc_skip;
        OP_JUMP: counter_n = target;
        OP_CALL: begin
`ifdef PC_STACK_PROTECT_EN
          if (full) begin
            counter_n  = pc_inc;
            overflow_n = 1'b1;
          end else begin
            push      = 1'b1;
            wr_n      = wr + IDX_W'(1);
            sp_n      = sp + SP_W'(1);
            counter_n = target;
          end
`else
          // Circular overwrite: when full the write lands on the oldest slot.
          push      = 1'b1;
          wr_n      = wr + IDX_W'(1);
          counter_n = target;
          if (full) overflow_n = 1'b1;
          else      sp_n       = sp + SP_W'(1);
`endif
        end
        OP_RET: begin
          if (empty) begin
            counter_n   = pc_inc;
            underflow_n = 1'b1;
          end else begin
            counter_n = stack_mem[wr_prev];
            wr_n      = wr_prev;
            sp_n      = sp - SP_W'(1);
          end
        end
        default: counter_n = pc_inc;
      endcase
    end
  end

  // Counter, pointers and sticky flags; reset overrides any pending operation.
  always_ff @(posedge clk) begin
    if (!reset) begin
      counter   <= RESET_VEC;
      sp        <= '0;
      wr        <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      counter   <= counter_n;
      sp        <= sp_n;
      wr        <= wr_n;
      overflow  <= overflow_n;
      underflow <= underflow_n;
    end
  end

  // Stack storage is not cleared; entries beyond sp are never observed.
  always_ff @(posedge clk) begin
    if (reset && push) stack_mem[wr] <= pc_inc;
  end

endmodule

// File: tb/tb_pcounter_stack.sv
// tb/tb_pcounter_stack.sv - scoreboard testbench for pcounter_stack
module tb_pcounter_stack;

  localparam int              PC_W      = 13;
  localparam int              DEPTH     = 8;
  localparam int              SP_W      = $clog2(DEPTH) + 1;
  localparam logic [PC_W-1:0] RESET_VEC = '0;

  localparam logic [2:0] OP_INC  = 3'b000;
  localparam logic [2:0] OP_SKIP = 3'b001;
  localparam logic [2:0] OP_JUMP = 3'b010;
  localparam logic [2:0] OP_CALL = 3'b011;
  localparam logic [2:0] OP_RET  = 3'b100;

  logic            clk;
  logic            reset;
  logic            en;
  logic [2:0]      op;
  logic [PC_W-1:0] target;
  logic [PC_W-1:0] counter;
  logic [SP_W-1:0] sp;
  logic [PC_W-1:0] tos;
  logic            full;
  logic            empty;
  logic            overflow;
  logic            underflow;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [PC_W-1:0] pc;
    logic [SP_W-1:0] sp;
    logic [PC_W-1:0] tos;
    logic            full;
    logic            empty;
    logic            ovf;
    logic            unf;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;

  // Reference model: queue-based stack, newest entry at the back.
  logic [PC_W-1:0] m_pc = '0;
  logic [PC_W-1:0] m_stk[$];
  logic            m_ovf = 1'b0;
  logic            m_unf = 1'b0;

  pcounter_stack #(.PC_W(PC_W), .DEPTH(DEPTH), .RESET_VEC(RESET_VEC)) dut (
    .clk(clk), .reset(reset), .en(en), .op(op), .target(target),
    .counter(counter), .sp(sp), .tos(tos), .full(full), .empty(empty),
    .overflow(overflow), .underflow(underflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  task automatic model_step(input logic r, input logic e, input logic [2:0] o,
                            input logic [PC_W-1:0] t);
    logic [PC_W-1:0] nxt;
    logic [PC_W-1:0] popped;
    exp_t x;
    nxt = m_pc + 13'd1;
    if (!r) begin
      m_pc = RESET_VEC;
      m_stk.delete();
      m_ovf = 1'b0;
      m_unf = 1'b0;
    end else if (e) begin
      case (o)
        OP_SKIP: m_pc = m_pc + 13'd2;
        OP_JUMP: m_pc = t;
        OP_CALL: begin
          if (m_stk.size() == DEPTH) begin
            m_ovf = 1'b1;
`ifdef PC_STACK_PROTECT_EN
            m_pc = nxt;
`else
            popped = m_stk.pop_front();
            m_stk.push_back(nxt);
            m_pc = t;
`endif
          end else begin
            m_stk.push_back(nxt);
            m_pc = t;
          end
        end
        OP_RET: begin
          if (m_stk.size() == 0) begin
            m_unf = 1'b1;
            m_pc  = nxt;
          end else begin
            m_pc = m_stk.pop_back();
          end
        end
        default: m_pc = nxt;
      endcase
    end
    x.pc    = m_pc;
    x.sp    = SP_W'(m_stk.size());
    x.tos   = (m_stk.size() > 0) ? m_stk[$] : '0;
    x.full  = (m_stk.size() == DEPTH);
    x.empty = (m_stk.size() == 0);
    x.ovf   = m_ovf;
    x.unf   = m_unf;
    sb.push_back(x);
  endtask

  // Drive one cycle, predict its outcome, and leave time for the monitor.
  task automatic drive(input logic r, input logic e, input logic [2:0] o,
                       input logic [PC_W-1:0] t);
    reset = r; en = e; op = o; target = t;
    model_step(r, e, o, t);
    @(posedge clk);
    #2;
  endtask

  // Scoreboard monitor: compare every cycle's outputs with the prediction.
  always @(posedge clk) begin
    #1;
    if (sb.size() > 0) begin
      mon_e = sb.pop_front();
      checks++;
      if (counter !== mon_e.pc) begin
        errors++; $display("FAIL sb_counter t=%0t got=%h exp=%h", $time, counter, mon_e.pc);
      end
      checks++;
      if (sp !== mon_e.sp) begin
        errors++; $display("FAIL sb_sp t=%0t got=%0d exp=%0d", $time, sp, mon_e.sp);
      end
      checks++;
      if (tos !== mon_e.tos) begin
        errors++; $display("FAIL sb_tos t=%0t got=%h exp=%h", $time, tos, mon_e.tos);
      end
      checks++;
      if ({full, empty} !== {mon_e.full, mon_e.empty}) begin
        errors++; $display("FAIL sb_full_empty t=%0t got=%b%b exp=%b%b", $time, full, empty, mon_e.full, mon_e.empty);
      end
      checks++;
      if ({overflow, underflow} !== {mon_e.ovf, mon_e.unf}) begin
        errors++; $display("FAIL sb_flags t=%0t got=%b%b exp=%b%b", $time, overflow, underflow, mon_e.ovf, mon_e.unf);
      end
    end
  end

  task automatic test_reset();
    drive(1'b0, 1'b1, OP_CALL, 13'd77);
    checks++;
    if ({counter, sp, tos, full, empty, overflow, underflow} !== {RESET_VEC, 4'd0, 13'd0, 4'b0100}) begin
      errors++; $display("FAIL reset_state got pc=%h sp=%0d tos=%h f=%b e=%b o=%b u=%b exp pc=0 sp=0 tos=0 e=1", counter, sp, tos, full, empty, overflow, underflow);
    end
  endtask

  task automatic test_inc();
    for (int i = 1; i <= 5; i++) begin
      drive(1'b1, 1'b1, OP_INC, 13'd0);
      checks++;
      if (counter !== 13'(i)) begin
        errors++; $display("FAIL inc_counter got=%0d exp=%0d", counter, i);
      end
    end
    checks++;
    if ({sp, empty, tos} !== {4'd0, 1'b1, 13'd0}) begin
      errors++; $display("FAIL inc_stack got sp=%0d empty=%b tos=%h exp sp=0 empty=1 tos=0", sp, empty, tos);
    end
  endtask

  task automatic test_call_ret();
    drive(1'b0, 1'b0, OP_INC, 13'd0);
    drive(1'b1, 1'b1, OP_JUMP, 13'd10);
    drive(1'b1, 1'b1, OP_CALL, 13'd100);
    checks++;
    if ({counter, sp, tos} !== {13'd100, 4'd1, 13'd11}) begin
      errors++; $display("FAIL call got pc=%0d sp=%0d tos=%0d exp pc=100 sp=1 tos=11", counter, sp, tos);
    end
    drive(1'b1, 1'b1, OP_INC, 13'd0);
    checks++;
    if ({counter, sp, tos} !== {13'd101, 4'd1, 13'd11}) begin
      errors++; $display("FAIL call_inc got pc=%0d sp=%0d tos=%0d exp pc=101 sp=1 tos=11", counter, sp, tos);
    end
    drive(1'b1, 1'b1, OP_RET, 13'd0);
    checks++;
    if ({counter, sp, tos} !== {13'd11, 4'd0, 13'd0}) begin
      errors++; $display("FAIL ret got pc=%0d sp=%0d tos=%0d exp pc=11 sp=0 tos=0", counter, sp, tos);
    end
  endtask

  task automatic test_nested();
    logic [PC_W-1:0] exp_pc;
    drive(1'b0, 1'b0, OP_INC, 13'd0);
    for (int i = 1; i <= 8; i++) drive(1'b1, 1'b1, OP_CALL, 13'(16 * i));
    checks++;
    if ({full, overflow} !== 2'b10) begin
      errors++; $display("FAIL nested_full got full=%b ovf=%b exp full=1 ovf=0", full, overflow);
    end
    drive(1'b1, 1'b1, OP_CALL, 13'd144);
`ifdef PC_STACK_PROTECT_EN
    exp_pc = 13'd129;
`else
    exp_pc = 13'd144;
`endif
    checks++;
    if ({counter, overflow, sp} !== {exp_pc, 1'b1, 4'd8}) begin
      errors++; $display("FAIL nested_ovf got pc=%0d ovf=%b sp=%0d exp pc=%0d ovf=1 sp=8", counter, overflow, sp, exp_pc);
    end
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, 1'b1, OP_RET, 13'd0);
`ifdef PC_STACK_PROTECT_EN
      exp_pc = 13'(113 - 16 * i);
`else
      exp_pc = 13'(129 - 16 * i);
`endif
      checks++;
      if (counter !== exp_pc) begin
        errors++; $display("FAIL nested_ret%0d got=%0d exp=%0d", i, counter, exp_pc);
      end
    end
    drive(1'b1, 1'b1, OP_RET, 13'd0);
    checks++;
    if ({underflow, sp, empty} !== {1'b1, 4'd0, 1'b1}) begin
      errors++; $display("FAIL underflow got unf=%b sp=%0d empty=%b exp unf=1 sp=0 empty=1", underflow, sp, empty);
    end
  endtask

  task automatic test_wrap();
    drive(1'b1, 1'b1, OP_JUMP, 13'h1FFE);
    drive(1'b1, 1'b1, OP_SKIP, 13'd0);
    checks++;
    if (counter !== 13'd0) begin
      errors++; $display("FAIL wrap_skip got=%h exp=0000", counter);
    end
    drive(1'b1, 1'b1, OP_JUMP, 13'h1FFF);
    drive(1'b1, 1'b1, OP_INC, 13'd0);
    checks++;
    if (counter !== 13'd0) begin
      errors++; $display("FAIL wrap_inc got=%h exp=0000", counter);
    end
    drive(1'b1, 1'b1, OP_JUMP, 13'h1FFF);
    drive(1'b1, 1'b1, OP_SKIP, 13'd0);
    checks++;
    if (counter !== 13'd1) begin
      errors++; $display("FAIL wrap_skip1 got=%h exp=0001", counter);
    end
    drive(1'b0, 1'b0, OP_INC, 13'd0);
    drive(1'b1, 1'b1, OP_JUMP, 13'h1FFF);
    drive(1'b1, 1'b1, OP_CALL, 13'd5);
    checks++;
    if ({counter, sp, tos} !== {13'd5, 4'd1, 13'd0}) begin
      errors++; $display("FAIL wrap_call got pc=%0d sp=%0d tos=%h exp pc=5 sp=1 tos=0", counter, sp, tos);
    end
  endtask

  task automatic test_hold();
    drive(1'b0, 1'b0, OP_INC, 13'd0);
    drive(1'b1, 1'b1, OP_JUMP, 13'd7);
    drive(1'b1, 1'b1, OP_CALL, 13'd200);
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 1'b0, OP_CALL, 13'd50);
      checks++;
      if ({counter, sp, tos} !== {13'd200, 4'd1, 13'd8}) begin
        errors++; $display("FAIL hold%0d got pc=%0d sp=%0d tos=%0d exp pc=200 sp=1 tos=8", i, counter, sp, tos);
      end
    end
  endtask

  task automatic test_reset_mid();
    drive(1'b0, 1'b0, OP_INC, 13'd0);
    drive(1'b1, 1'b1, OP_RET, 13'd0);
    drive(1'b1, 1'b1, OP_CALL, 13'd300);
    drive(1'b0, 1'b1, OP_CALL, 13'd400);
    checks++;
    if ({counter, sp, tos, overflow, underflow} !== {RESET_VEC, 4'd0, 13'd0, 2'b00}) begin
      errors++; $display("FAIL reset_mid got pc=%0d sp=%0d tos=%0d o=%b u=%b exp pc=0 sp=0 tos=0 o=0 u=0", counter, sp, tos, overflow, underflow);
    end
  endtask

  task automatic test_back_to_back();
    drive(1'b1, 1'b1, OP_JUMP, 13'd40);
    drive(1'b1, 1'b1, OP_CALL, 13'd60);
    drive(1'b1, 1'b1, OP_RET, 13'd0);
    checks++;
    if (counter !== 13'd41) begin
      errors++; $display("FAIL b2b_ret1 got=%0d exp=41", counter);
    end
    drive(1'b1, 1'b1, OP_CALL, 13'd70);
    drive(1'b1, 1'b1, OP_CALL, 13'd80);
    drive(1'b1, 1'b1, OP_RET, 13'd0);
    checks++;
    if (counter !== 13'd71) begin
      errors++; $display("FAIL b2b_ret2 got=%0d exp=71", counter);
    end
    drive(1'b1, 1'b1, OP_RET, 13'd0);
    checks++;
    if ({counter, sp} !== {13'd42, 4'd0}) begin
      errors++; $display("FAIL b2b_ret3 got pc=%0d sp=%0d exp pc=42 sp=0", counter, sp);
    end
    drive(1'b1, 1'b1, 3'b111, 13'd0);
    checks++;
    if (counter !== 13'd43) begin
      errors++; $display("FAIL illegal_op got=%0d exp=43", counter);
    end
  endtask

  initial begin
    reset = 1'b0; en = 1'b0; op = OP_INC; target = '0;
    test_reset();
    test_inc();
    test_call_ret();
    test_nested();
    test_wrap();
    test_hold();
    test_reset_mid();
    test_back_to_back();
    @(posedge clk);
    #3;
    checks++;
    if (sb.size() != 0) begin
      errors++; $display("FAIL sb_drain got=%0d pending exp=0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pcounter_stack.md
Name: pcounter_stack

Overview:
- Parametrised successor to the flat program counter: PC plus a hardware call/return stack.
- Supports sequential increment, skip, absolute jump, call (push return address) and return (pop).
- Sits between decode (which supplies op/target) and program memory addressing; `counter` drives the instruction fetch address.
- All state updates occur on the rising edge of `clk`.

Parameters:
- PC_W, 13, width of program counter and of each stack entry.
- DEPTH, 8, number of stack entries (power of two, >= 2).
- RESET_VEC, 0, value loaded into counter on reset (PC_W bits).

Ports:
- clk  input  1  system clock, rising-edge.
- reset  input  1  synchronous, active-low reset (asserted when 0, sampled on rising edge of clk).
- en  input  1  advance enable; 0 = hold all state.
- op  input  3  operation: 000 INC, 001 SKIP, 010 JUMP, 011 CALL, 100 RET, others treated as INC.
- target  input  PC_W  destination address for JUMP/CALL.
- counter  output  PC_W  current program counter (registered).
- sp  output  $clog2(DEPTH)+1  number of valid stack entries, 0..DEPTH.
- tos  output  PC_W  top-of-stack value; 0 when sp==0.
- full  output  1  sp==DEPTH.
- empty  output  1  sp==0.
- overflow  output  1  sticky: CALL issued while full.
- underflow  output  1  sticky: RET issued while empty.

Behaviour:
- Reset (reset==0 at rising edge): counter=RESET_VEC, sp=0, stack pointer/write index=0, overflow=0, underflow=0, tos=0. Stack RAM contents need not be cleared. Reset overrides en and op, including mid-sequence (e.g. a pending CALL is discarded).
- en==0: counter, sp, stack, flags all hold.
- en==1, result visible one cycle after the edge:
  - INC: counter <= counter+1.
  - SKIP: counter <= counter+2.
  - JUMP: counter <= target; stack untouched.
  - CALL: stack[wr] <= counter+1; wr <= wr+1 mod DEPTH; counter <= target; sp <= min(sp+1, DEPTH).
  - RET (sp>0): counter <= stack[wr-1 mod DEPTH]; wr <= wr-1 mod DEPTH; sp <= sp-1.
- Arithmetic: all PC additions are modulo 2^PC_W. 13'h1FFF+1 = 0; 13'h1FFE+2 = 0; 13'h1FFF+2 = 1. A CALL from 13'h1FFF pushes 0.
- Overflow (CALL while full, default build): the oldest entry is overwritten circularly (wr advances, sp stays DEPTH), the jump is taken, and overflow is set sticky.
- Underflow (RET while empty): counter <= counter+1, sp stays 0, wr unchanged, underflow set sticky.
- Sticky flags clear only on reset.
- tos is combinational from the registered stack and wr: stack[wr-1] when sp>0, else 0.
- full/empty are combinational from sp.
- Back-to-back CALL/RET on consecutive cycles must work with no bubble. A RET immediately after a CALL returns to the CALL address+1.

Optional Feature:
- Macro: PC_STACK_PROTECT_EN.
- Defined:
  - CALL while full is rejected: no push, counter <= counter+1 (call not taken), sp/wr unchanged, overflow set sticky.
  - RET while empty behaves as in the default build.
  - Stack never loses entries.
- Not defined: circular overwrite on overflow, as described under Behaviour.

Test Plan:
- Reset then 5 cycles INC with en=1 -> counter 0,1,2,3,4,5; sp=0, empty=1, tos=0.
- counter=10, CALL target=100, then INC, then RET -> counter 100, 101, then 11; sp 1,1,0; tos=11 while sp=1.
- 9 nested CALLs from counter=0 (targets 16,32,...,144) with DEPTH=8 -> after 8th call full=1, overflow=0; 9th sets overflow=1.
  - Default build: 8 RETs return 129,113,...,17 (oldest return 1 lost); 9th RET sets underflow=1.
  - PROTECT build: 9th call not taken (counter=129), and the 8 RETs return 113,...,17,1.
- JUMP target=13'h1FFE then SKIP -> counter=0; then JUMP 13'h1FFF, INC -> counter=0.
- en=0 for 3 cycles with op=CALL, target=50 -> counter, sp, tos unchanged.
- CALL issued, then reset=0 asserted on the next edge -> counter=RESET_VEC, sp=0, overflow=underflow=0.
